seq_shift_add_multiplier: RTL and testbench

Parametrised sequential shift-and-add multiplier, successor to the fixed 4x2 gate-level multiplier. It processes one multiplier bit per clock using a shared add/subtract datapath and supports unsigned and two's-complement signed operands selected per operation. A Start/Busy/Done handshake lets a controller issue back-to-back operations. The product is held in a register until the next result completes.

---
 rtl/seq_shift_add_multiplier.sv | 117 +++++++++++
 tb/tb_seq_shift_add_multiplier.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-and-add multiplier, one multiplier bit per clock, unsigned or
// two's-complement operands selected per operation.
//
// state | meaning
// IDLE  | waiting for Start; Output holds the last product
// RUN   | consuming one multiplier bit per edge, LSB first
module seq_shift_add_multiplier #(
   parameter  int WidthA = 8,
   parameter  int WidthB = 8,
   localparam int WidthP = WidthA + WidthB
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Start,
   input  logic              Mode,
   input  logic [WidthA-1:0] Input1,
   input  logic [WidthB-1:0] Input2,
   output logic              Busy,
   output logic              Done,
   output logic [WidthP-1:0] Output
);

   localparam int CntW = (WidthB > 1) ? $clog2(WidthB) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state, state_nxt;
   logic [WidthP-1:0] a_sh;
   logic [WidthB-1:0] b_sh;
   logic              mode_r;
   logic [CntW-1:0]   cnt;
   logic [WidthP-1:0] acc;
   logic [WidthP-1:0] prod;
   logic              done_r;

   logic              accept;
   logic              finish;
   logic              last;
   logic              sub;
   logic [WidthP-1:0] addend;
   logic [WidthP-1:0] operand;
   logic [WidthP-1:0] sum;
   logic [WidthP-1:0] a_ext;

   assign last  = (cnt == CntW'(WidthB - 1));
   assign a_ext = {{WidthB{Mode & Input1[WidthA-1]}}, Input1};

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            if (Start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (last) begin
               finish    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Single shared adder; the multiplier's sign bit carries negative weight,
   // handled as invert plus carry-in.
   always_comb begin
      addend  = b_sh[0] ? a_sh : '0;
      sub     = mode_r & last;
      operand = sub ? ~addend : addend;
      sum     = acc + operand + WidthP'(sub);
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         a_sh   <= '0;
         b_sh   <= '0;
         mode_r <= 1'b0;
         cnt    <= '0;
         acc    <= '0;
         prod   <= '0;
         done_r <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (accept) begin
            a_sh   <= a_ext;
            b_sh   <= Input2;
            mode_r <= Mode;
            acc    <= '0;
            cnt    <= '0;
         end else if (state == RUN) begin
            acc  <= sum;
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
            cnt  <= cnt + CntW'(1);
            if (finish) begin
               prod   <= sum;
               done_r <= 1'b1;
            end
         end
      end
   end

   assign Busy   = (state == RUN);
   assign Done   = done_r;
   assign Output = prod;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Scoreboard bench for seq_shift_add_multiplier at 8x8, 4x2 and 4x1 widths,
// checked against a plain signed/unsigned arithmetic reference.
module tb_seq_shift_add_multiplier;

   logic Clock = 1'b0;
   logic Reset;

   logic        s8, m8, busy8, done8;
   logic [7:0]  a8, b8;
   logic [15:0] out8;
   logic        s42, m42, busy42, done42;
   logic [3:0]  a42;
   logic [1:0]  b42;
   logic [5:0]  out42;
   logic        s41, m41, busy41, done41;
   logic [3:0]  a41;
   logic [0:0]  b41;
   logic [4:0]  out41;

   int n_cmp = 0;
   int n_err = 0;
   longint unsigned q8[$], q42[$], q41[$];

   seq_shift_add_multiplier #(.WidthA(8), .WidthB(8)) dut8 (
      .Clock(Clock), .Reset(Reset), .Start(s8), .Mode(m8), .Input1(a8),
      .Input2(b8), .Busy(busy8), .Done(done8), .Output(out8));

   seq_shift_add_multiplier #(.WidthA(4), .WidthB(2)) dut42 (
      .Clock(Clock), .Reset(Reset), .Start(s42), .Mode(m42), .Input1(a42),
      .Input2(b42), .Busy(busy42), .Done(done42), .Output(out42));

   seq_shift_add_multiplier #(.WidthA(4), .WidthB(1)) dut41 (
      .Clock(Clock), .Reset(Reset), .Start(s41), .Mode(m41), .Input1(a41),
      .Input2(b41), .Busy(busy41), .Done(done41), .Output(out41));

   always #5 Clock = ~Clock;

   function automatic longint unsigned ref_mul(input int wa, input int wb,
         input longint unsigned a, input longint unsigned b, input bit m);
      longint sa, sb, p;
      longint unsigned mask;
      sa = longint'(a);
      sb = longint'(b);
      if (m && a[wa-1]) sa = sa - (longint'(1) << wa);
      if (m && b[wb-1]) sb = sb - (longint'(1) << wb);
      p    = sa * sb;
      mask = (64'd1 << (wa + wb)) - 64'd1;
      return 64'(p) & mask;
   endfunction

   task automatic check(input string nm, input longint unsigned act, input longint unsigned exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitors: compare on Done, check Output holds otherwise, check Busy length.
   longint unsigned last8 = 0, last42 = 0, last41 = 0;
   int bc8 = 0, bc42 = 0, bc41 = 0;
   bit pb8 = 0, pb42 = 0, pb41 = 0;

   always @(negedge Clock) begin
      if (Reset) begin
         last8 = 0; bc8 = 0; pb8 = 0;
      end else begin
         if (done8) begin
            if (q8.size() == 0) check("done8_unexpected", 1, 0);
            else                check("out8", out8, q8.pop_front());
            check("busy8_len", bc8, 8);
            check("done8_after_busy", pb8, 1);
            bc8   = 0;
            last8 = out8;
         end else begin
            check("out8_hold", out8, last8);
         end
         if (busy8) bc8++;
         pb8 = busy8;
      end
   end

   always @(negedge Clock) begin
      if (Reset) begin
         last42 = 0; bc42 = 0; pb42 = 0;
      end else begin
         if (done42) begin
            if (q42.size() == 0) check("done42_unexpected", 1, 0);
            else                 check("out42", out42, q42.pop_front());
            check("busy42_len", bc42, 2);
            check("done42_after_busy", pb42, 1);
            bc42   = 0;
            last42 = out42;
         end else begin
            check("out42_hold", out42, last42);
         end
         if (busy42) bc42++;
         pb42 = busy42;
      end
   end

   always @(negedge Clock) begin
      if (Reset) begin
         last41 = 0; bc41 = 0; pb41 = 0;
      end else begin
         if (done41) begin
            if (q41.size() == 0) check("done41_unexpected", 1, 0);
            else                 check("out41", out41, q41.pop_front());
            check("busy41_len", bc41, 1);
            check("done41_after_busy", pb41, 1);
            bc41   = 0;
            last41 = out41;
         end else begin
            check("out41_hold", out41, last41);
         end
         if (busy41) bc41++;
         pb41 = busy41;
      end
   end

   task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic m);
      int t = 0;
      while (busy8 && t < 100) begin @(negedge Clock); t++; end
      if (t >= 100) check("issue8_timeout", 1, 0);
      s8 = 1'b1; a8 = a; b8 = b; m8 = m;
      q8.push_back(ref_mul(8, 8, a, b, m));
      @(negedge Clock);
      s8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); m8 = 1'($urandom);
   endtask

   task automatic issue42(input logic [3:0] a, input logic [1:0] b, input logic m);
      int t = 0;
      while (busy42 && t < 100) begin @(negedge Clock); t++; end
      if (t >= 100) check("issue42_timeout", 1, 0);
      s42 = 1'b1; a42 = a; b42 = b; m42 = m;
      q42.push_back(ref_mul(4, 2, a, b, m));
      @(negedge Clock);
      s42 = 1'b0; a42 = 4'($urandom); b42 = 2'($urandom); m42 = 1'($urandom);
   endtask

   task automatic issue41(input logic [3:0] a, input logic [0:0] b, input logic m);
      int t = 0;
      while (busy41 && t < 100) begin @(negedge Clock); t++; end
      if (t >= 100) check("issue41_timeout", 1, 0);
      s41 = 1'b1; a41 = a; b41 = b; m41 = m;
      q41.push_back(ref_mul(4, 1, a, b, m));
      @(negedge Clock);
      s41 = 1'b0; a41 = 4'($urandom); b41 = 1'($urandom); m41 = 1'($urandom);
   endtask

   initial begin
      Reset = 1'b1;
      s8 = 0; m8 = 0; a8 = 0; b8 = 0;
      s42 = 0; m42 = 0; a42 = 0; b42 = 0;
      s41 = 0; m41 = 0; a41 = 0; b41 = 0;
      #1;
      check("rst_busy8", busy8, 0);
      check("rst_done8", done8, 0);
      check("rst_out8", out8, 0);
      check("rst_out42", out42, 0);
      check("rst_out41", out41, 0);
      @(negedge Clock);
      @(negedge Clock);
      #2 Reset = 1'b0;

      issue42(4'd15, 2'd3, 1'b0);
      issue42(4'h8, 2'h2, 1'b1);
      issue42(4'h7, 2'h3, 1'b1);
      for (int i = 0; i < 20; i++) issue42(4'($urandom), 2'($urandom), 1'($urandom));

      issue8(8'hFF, 8'hFF, 1'b0);
      issue8(8'hFF, 8'h01, 1'b1);
      issue8(8'h80, 8'h80, 1'b1);
      issue8(8'h7F, 8'h80, 1'b1);

      // Start held for the whole run with shifting operands, then straight into
      // a back-to-back operation accepted in the Done cycle.
      issue8(8'h5A, 8'hC3, 1'b1);
      for (int i = 0; i < 8; i++) begin
         s8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); m8 = 1'($urandom);
         @(negedge Clock);
      end
      check("spam_idle_in_done", busy8, 0);
      issue8(8'h12, 8'h34, 1'b0);
      for (int i = 0; i < 40; i++) issue8(8'($urandom), 8'($urandom), 1'($urandom));

      // Abort mid-operation with an asynchronous reset.
      issue8(8'hA5, 8'h3C, 1'b0);
      @(negedge Clock);
      @(negedge Clock);
      #2 Reset = 1'b1;
      #1;
      check("abort_busy8", busy8, 0);
      check("abort_done8", done8, 0);
      check("abort_out8", out8, 0);
      void'(q8.pop_back());
      @(negedge Clock);
      #2 Reset = 1'b0;
      repeat (12) @(negedge Clock);
      issue8(8'h00, 8'($urandom), 1'($urandom));

      issue41(4'h3, 1'b1, 1'b1);
      issue41(4'h3, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) issue41(4'($urandom), 1'($urandom), 1'($urandom));

      for (int t = 0; t < 60; t++) begin
         if (q8.size() == 0 && q42.size() == 0 && q41.size() == 0 &&
             !busy8 && !busy42 && !busy41) break;
         @(negedge Clock);
      end
      repeat (3) @(negedge Clock);
      check("q8_drained", q8.size(), 0);
      check("q42_drained", q42.size(), 0);
      check("q41_drained", q41.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
